// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - move-command front end emitting timed ENABLE step strobes
// Optional STEP_RAMP_EN: steps at each end of a move use double period.
module step_sequencer #(
  parameter int CNT_W      = 16,
  parameter int DIV_W      = 20,
  parameter int RAMP_STEPS = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic [CNT_W-1:0] STEPS,
  input  logic [DIV_W-1:0] PERIOD,
  input  logic             DIR,
  input  logic             MODE_HALF,
  output logic             ENABLE,
  output logic             UP_DOWN,
  output logic             HALF_FULL,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] STEPS_LEFT
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] period_q, period_nx;
  logic [DIV_W:0]   div_q, div_nx;
  logic             enable_nx, up_nx, half_nx, busy_nx, done_nx;
  logic [CNT_W-1:0] left_nx;
  logic [CNT_W-1:0] pending;
  logic [DIV_W-1:0] p_cmd;
  logic [DIV_W:0]   ival_first, ival_start2, ival_run;
  logic             accept;

  assign p_cmd  = (PERIOD == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : PERIOD;
  assign accept = (state == IDLE) && START && !STOP;

  // STEPS_LEFT lags ENABLE by a cycle, so a strobe still on the wire is already spent
  assign pending = STEPS_LEFT - {{(CNT_W-1){1'b0}}, ENABLE};

`ifdef STEP_RAMP_EN
  localparam logic [CNT_W:0] RAMP_N = (CNT_W+1)'(RAMP_STEPS);

  logic [CNT_W-1:0] total_q;
  logic [CNT_W:0]   k_run;

  function automatic logic is_ramp(input logic [CNT_W:0] k, input logic [CNT_W:0] n);
    return (k < RAMP_N) || ((n - k) <= RAMP_N);
  endfunction

  // index of the strobe that follows the one being issued now
  assign k_run = {1'b0, total_q} - {1'b0, pending} + (CNT_W+1)'(1);

  assign ival_first  = is_ramp('0, {1'b0, STEPS}) ? {p_cmd, 1'b0} : {1'b0, p_cmd};
  assign ival_start2 = is_ramp((CNT_W+1)'(1), {1'b0, STEPS}) ? {p_cmd, 1'b0} : {1'b0, p_cmd};
  assign ival_run    = is_ramp(k_run, {1'b0, total_q}) ? {period_q, 1'b0} : {1'b0, period_q};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      total_q <= '0;
    end else if (accept) begin
      total_q <= STEPS;
    end
  end
`else
  assign ival_first  = {1'b0, p_cmd};
  assign ival_start2 = {1'b0, p_cmd};
  assign ival_run    = {1'b0, period_q};
`endif

  always_comb begin
    state_nx  = state;
    period_nx = period_q;
    div_nx    = div_q;
    enable_nx = 1'b0;
    up_nx     = UP_DOWN;
    half_nx   = HALF_FULL;
    busy_nx   = BUSY;
    done_nx   = 1'b0;
    left_nx   = STEPS_LEFT;
    case (state)
      IDLE: begin
        if (accept) begin
          if (STEPS == '0) begin
            state_nx = FIN;
            done_nx  = 1'b1;
          end else begin
            state_nx  = RUN;
            busy_nx   = 1'b1;
            up_nx     = DIR;
            half_nx   = MODE_HALF;
            left_nx   = STEPS;
            period_nx = p_cmd;
            // a one-cycle first interval strobes on the latch edge itself
            if (ival_first == (DIV_W+1)'(1)) begin
              enable_nx = 1'b1;
              div_nx    = ival_start2;
            end else begin
              div_nx = ival_first - (DIV_W+1)'(1);
            end
          end
        end
      end
      RUN: begin
        left_nx = pending;
        if (STOP || (ENABLE && STEPS_LEFT == (CNT_W)'(1))) begin
          state_nx = FIN;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
        end else if (div_q <= (DIV_W+1)'(1)) begin
          enable_nx = 1'b1;
          div_nx    = ival_run;
        end else begin
          div_nx = div_q - (DIV_W+1)'(1);
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      period_q   <= '0;
      div_q      <= '0;
      ENABLE     <= 1'b0;
      UP_DOWN    <= 1'b1;
      HALF_FULL  <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      STEPS_LEFT <= '0;
    end else begin
      state      <= state_nx;
      period_q   <= period_nx;
      div_q      <= div_nx;
      ENABLE     <= enable_nx;
      UP_DOWN    <= up_nx;
      HALF_FULL  <= half_nx;
      BUSY       <= busy_nx;
      DONE       <= done_nx;
      STEPS_LEFT <= left_nx;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - randomized and directed checks of step_sequencer against a timeline model
module tb_step_sequencer;

  localparam int CNT_W = 16;
  localparam int DIV_W = 20;
  localparam int RAMP  = 2;
`ifdef STEP_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             START = 1'b0;
  logic             STOP = 1'b0;
  logic [CNT_W-1:0] STEPS = '0;
  logic [DIV_W-1:0] PERIOD = '0;
  logic             DIR = 1'b0;
  logic             MODE_HALF = 1'b0;
  logic             ENABLE, UP_DOWN, HALF_FULL, BUSY, DONE;
  logic [CNT_W-1:0] STEPS_LEFT;

  step_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .RAMP_STEPS(RAMP)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .STEPS(STEPS),
    .PERIOD(PERIOD), .DIR(DIR), .MODE_HALF(MODE_HALF), .ENABLE(ENABLE),
    .UP_DOWN(UP_DOWN), .HALF_FULL(HALF_FULL), .BUSY(BUSY), .DONE(DONE),
    .STEPS_LEFT(STEPS_LEFT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // model: each accepted move is a list of absolute strobe cycles
  bit m_active = 1'b0;
  int m_t0, m_end, m_start_left;
  int m_base_left = 0;
  bit m_up = 1'b1, m_half = 1'b1;
  int sched[$];

  bit exp_valid = 1'b0;
  bit exp_en, exp_up, exp_half, exp_busy, exp_done;
  int exp_left;

  int en_log[$];
  int done_log[$];
  bit busy_seen;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
  endfunction

  function automatic int ival(int k, int n, int pe);
    if (RAMP_ON && (k < RAMP || k >= n - RAMP)) return 2 * pe;
    return pe;
  endfunction

  function automatic void model_expect(int c);
    int cnt;
    exp_up = m_up; exp_half = m_half;
    exp_en = 0; exp_busy = 0; exp_done = 0; exp_left = m_base_left;
    if (m_active) begin
      exp_busy = (c > m_t0) && (c <= m_end);
      exp_done = (c == m_end + 1);
      if (c > m_t0) begin
        cnt = 0;
        foreach (sched[k]) begin
          if (sched[k] <= m_end) begin
            if (sched[k] == c) exp_en = 1;
            if (sched[k] < c) cnt++;
          end
        end
        exp_left = m_start_left - cnt;
      end
    end
  endfunction

  function automatic void model_step(int c, bit st, bit sp, int n, int p, bit d, bit h);
    int t, pe;
    if (m_active && sp && c > m_t0 && c <= m_end) begin
      m_end = c;
    end else if (st && !sp && (!m_active || c > m_end + 1)) begin
      m_active = 1; m_t0 = c; m_base_left = exp_left;
      sched.delete();
      if (n == 0) begin
        m_end = c; m_start_left = exp_left;
      end else begin
        pe = (p == 0) ? 1 : p;
        t = c;
        for (int k = 0; k < n; k++) begin
          t += ival(k, n, pe);
          sched.push_back(t);
        end
        m_end = t; m_start_left = n; m_up = d; m_half = h;
      end
    end
  endfunction

  task automatic cycle_in(input bit rst_n, input bit st, input bit sp, input int n,
                          input int p, input bit d, input bit h);
    @(posedge CLK); #1;
    cyc++;
    model_expect(cyc);
    RESET = rst_n; START = st; STOP = sp;
    STEPS = CNT_W'(n); PERIOD = DIV_W'(p); DIR = d; MODE_HALF = h;
    if (!rst_n) begin
      exp_en = 0; exp_up = 1; exp_half = 1; exp_busy = 0; exp_done = 0; exp_left = 0;
      m_active = 0; m_base_left = 0; m_up = 1; m_half = 1;
    end else begin
      model_step(cyc, st, sp, n, p, d, h);
    end
    exp_valid = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_in(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input int n, input int p, input bit d, input bit h);
    cycle_in(1, 1, 0, n, p, d, h);
  endtask

  task automatic clear_logs();
    en_log.delete(); done_log.delete(); busy_seen = 0;
  endtask

  always @(negedge CLK) begin
    if (exp_valid) begin
      chk("ENABLE", ENABLE, exp_en);
      chk("UP_DOWN", UP_DOWN, exp_up);
      chk("HALF_FULL", HALF_FULL, exp_half);
      chk("BUSY", BUSY, exp_busy);
      chk("DONE", DONE, exp_done);
      chk("STEPS_LEFT", STEPS_LEFT, exp_left);
      if (ENABLE) en_log.push_back(cyc);
      if (DONE) done_log.push_back(cyc);
      if (BUSY) busy_seen = 1;
    end
  end

  initial begin
    int t0, t1;
    int gaps[6];
    gaps = '{4, 4, 2, 2, 4, 4};

    cycle_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); #1;
    chk("reset_up", UP_DOWN, 1);
    chk("reset_half", HALF_FULL, 1);
    chk("reset_left", STEPS_LEFT, 0);
    idle(3);

    // 1: four strobes every 3 cycles
    clear_logs();
    cmd(4, 3, 1, 1); t0 = cyc;
    for (int i = 0; i < 4; i++) chk("t1_model_sched", sched[i], t0 + 3 * (i + 1));
    idle(16);
    chk("t1_en_count", en_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_en_cycle", en_log[i], t0 + 3 * (i + 1));
    chk("t1_done_count", done_log.size(), 1);
    chk("t1_done_cycle", done_log[0], t0 + 13);

    // 2: PERIOD 0 gives back-to-back strobes
    clear_logs();
    cmd(3, 0, 0, 0); t0 = cyc;
    idle(8);
    chk("t2_en_count", en_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_en_cycle", en_log[i], t0 + 1 + i);
    chk("t2_up_down", UP_DOWN, 0);
    chk("t2_left", STEPS_LEFT, 0);

    // 3: STOP one cycle after the second strobe
    clear_logs();
    cmd(5, 4, 1, 0); t0 = cyc;
    idle(8);
    cycle_in(1, 0, 1, 0, 0, 0, 0);
    idle(6);
    chk("t3_en_count", en_log.size(), 2);
    chk("t3_done_cycle", done_log[0], t0 + 10);
    chk("t3_left", STEPS_LEFT, 3);

    // 4: zero-step move, then START during BUSY
    clear_logs();
    cmd(0, 3, 0, 1); t0 = cyc;
    idle(4);
    chk("t4_zero_done", done_log.size(), 1);
    chk("t4_zero_done_cycle", done_log[0], t0 + 1);
    chk("t4_zero_en", en_log.size(), 0);
    chk("t4_zero_busy", busy_seen, 0);
    clear_logs();
    cmd(6, 2, 1, 1); t0 = cyc;
    idle(2);
    cmd(1, 0, 0, 0);
    idle(16);
    chk("t4_busy_en_count", en_log.size(), 6);
    chk("t4_busy_done_cycle", done_log[0], t0 + 13);
    chk("t4_busy_left", STEPS_LEFT, 0);

    // 5: reset mid-move, then a fresh move
    clear_logs();
    cmd(8, 3, 0, 0); t0 = cyc;
    idle(6);
    cycle_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); #1;
    chk("t5_rst_en", ENABLE, 0);
    chk("t5_rst_up", UP_DOWN, 1);
    chk("t5_rst_left", STEPS_LEFT, 0);
    cycle_in(0, 0, 0, 0, 0, 0, 0);
    idle(6);
    chk("t5_no_done", done_log.size(), 0);
    chk("t5_en_count", en_log.size(), 2);
    clear_logs();
    cmd(2, 1, 1, 0); t1 = cyc;
    idle(5);
    chk("t5_new_en0", en_log[0], t1 + 1);
    chk("t5_new_en1", en_log[1], t1 + 2);
    chk("t5_new_done", done_log[0], t1 + 3);

`ifdef STEP_RAMP_EN
    // 6: ramp spacing
    clear_logs();
    cmd(6, 2, 1, 1); t0 = cyc;
    idle(24);
    chk("t6_en_count", en_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t6_gap", en_log[i] - ((i == 0) ? t0 : en_log[i-1]), gaps[i]);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle_in($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 29) == 0, int'($urandom_range(0, 9)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    idle(80);

    @(negedge CLK); #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
